// File: rtl/macguffin_ctrl_pkg.sv
// Shared constants and types for the MacGuffin command controller.
package macguffin_ctrl_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned KEY_W     = 48;
  localparam int unsigned BLK_W     = 64;
  localparam int unsigned KEY_BYTES = 6;
  localparam int unsigned BLK_BYTES = 8;

  localparam logic [7:0] OP_KEY = 8'h4B;
  localparam logic [7:0] OP_ENC = 8'h45;
  localparam logic [7:0] ST_ACK = 8'h06;
  localparam logic [7:0] ST_NAK = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RX_KEY     = 3'd1,
    S_RX_DATA    = 3'd2,
    S_CRYPT_SEND = 3'd3,
    S_CRYPT_WAIT = 3'd4,
    S_TX_DATA    = 3'd5,
    S_TX_STAT    = 3'd6
  } ctrl_state_t;

endpackage

// File: rtl/macguffin_cmd_ctrl_frame_timer.sv
// Inter-byte frame timer: reloads on clear, counts down while enabled,
// flags expiry combinationally once the idle budget is used up.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire_c
);

  localparam logic [31:0] LOAD = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      r_cnt <= LOAD;
    else if (i_clear)                r_cnt <= LOAD;
    else if (i_en && (r_cnt != '0))  r_cnt <= r_cnt - 32'd1;
  end

  assign o_expire_c = i_en && (r_cnt == '0);

endmodule

// File: rtl/macguffin_cmd_ctrl.sv
// Byte-stream command parser that loads the cipher key, feeds one block at
// a time to the MacGuffin core and serialises the result or a status byte.
module macguffin_cmd_ctrl
  import macguffin_ctrl_pkg::*;
#(
  parameter logic [47:0] INIT_KEY       = 48'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] c_m_axis_tdata,
  output logic        c_m_axis_tvalid,
  input  logic        c_m_axis_tready,
  input  logic [63:0] c_s_axis_tdata,
  input  logic        c_s_axis_tvalid,
  output logic        c_s_axis_tready,
  output logic [47:0] key,
  output logic        busy,
  output logic        frame_err
);

  ctrl_state_t r_state, w_state_nxt;
  logic [2:0]  r_idx, w_idx_nxt;
  logic [39:0] r_kstage, w_kstage_nxt;
  logic [47:0] r_key, w_key_nxt;
  logic [63:0] r_blk, w_blk_nxt;
  logic [63:0] r_res, w_res_nxt;
  logic [7:0]  r_m_tdata, w_m_tdata_nxt;
  logic        r_s_tready, w_s_tready_nxt;
  logic        r_m_tvalid, w_m_tvalid_nxt;
  logic        r_cm_tvalid, w_cm_tvalid_nxt;
  logic        r_cs_tready, w_cs_tready_nxt;
  logic        r_busy, w_busy_nxt;
  logic        r_frame_err, w_frame_err_nxt;

  logic w_s_hs;
  logic w_timer_en;
  logic w_expire_c;

  assign w_s_hs     = s_axis_tvalid && r_s_tready;
  assign w_timer_en = (r_state == S_RX_KEY) || (r_state == S_RX_DATA);

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_frame_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_s_hs),
    .i_en       (w_timer_en),
    .o_expire_c (w_expire_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_kstage    <= '0;
      r_key       <= INIT_KEY;
      r_blk       <= '0;
      r_res       <= '0;
      r_m_tdata   <= '0;
      r_s_tready  <= 1'b0;
      r_m_tvalid  <= 1'b0;
      r_cm_tvalid <= 1'b0;
      r_cs_tready <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_kstage    <= w_kstage_nxt;
      r_key       <= w_key_nxt;
      r_blk       <= w_blk_nxt;
      r_res       <= w_res_nxt;
      r_m_tdata   <= w_m_tdata_nxt;
      r_s_tready  <= w_s_tready_nxt;
      r_m_tvalid  <= w_m_tvalid_nxt;
      r_cm_tvalid <= w_cm_tvalid_nxt;
      r_cs_tready <= w_cs_tready_nxt;
      r_busy      <= w_busy_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Next-state and next-output logic; a byte in the expiry cycle beats the timeout.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_kstage_nxt    = r_kstage;
    w_key_nxt       = r_key;
    w_blk_nxt       = r_blk;
    w_res_nxt       = r_res;
    w_m_tdata_nxt   = r_m_tdata;
    w_m_tvalid_nxt  = r_m_tvalid;
    w_cm_tvalid_nxt = r_cm_tvalid;
    w_cs_tready_nxt = r_cs_tready;
    w_frame_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_s_hs) begin
          w_idx_nxt = '0;
          if (s_axis_tdata == OP_KEY) begin
            w_state_nxt = S_RX_KEY;
          end else if (s_axis_tdata == OP_ENC) begin
            w_state_nxt = S_RX_DATA;
          end else begin
            w_state_nxt     = S_TX_STAT;
            w_m_tvalid_nxt  = 1'b1;
            w_m_tdata_nxt   = ST_NAK;
            w_frame_err_nxt = 1'b1;
          end
        end
      end
      S_RX_KEY: begin
        if (w_s_hs) begin
          w_kstage_nxt = {r_kstage[31:0], s_axis_tdata};
          if (r_idx == 3'(KEY_BYTES - 1)) begin
            w_key_nxt      = {r_kstage, s_axis_tdata};
            w_state_nxt    = S_TX_STAT;
            w_m_tvalid_nxt = 1'b1;
            w_m_tdata_nxt  = ST_ACK;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else if (w_expire_c) begin
          w_state_nxt     = S_TX_STAT;
          w_m_tvalid_nxt  = 1'b1;
          w_m_tdata_nxt   = ST_NAK;
          w_frame_err_nxt = 1'b1;
        end
      end
      S_RX_DATA: begin
        if (w_s_hs) begin
          w_blk_nxt = {r_blk[55:0], s_axis_tdata};
          if (r_idx == 3'(BLK_BYTES - 1)) begin
            w_state_nxt     = S_CRYPT_SEND;
            w_cm_tvalid_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end else if (w_expire_c) begin
          w_state_nxt     = S_TX_STAT;
          w_m_tvalid_nxt  = 1'b1;
          w_m_tdata_nxt   = ST_NAK;
          w_frame_err_nxt = 1'b1;
        end
      end
      S_CRYPT_SEND: begin
        if (c_m_axis_tready) begin
          w_cm_tvalid_nxt = 1'b0;
          w_cs_tready_nxt = 1'b1;
          w_state_nxt     = S_CRYPT_WAIT;
        end
      end
      S_CRYPT_WAIT: begin
        if (c_s_axis_tvalid) begin
          w_cs_tready_nxt = 1'b0;
          w_state_nxt     = S_TX_DATA;
          w_idx_nxt       = '0;
          w_m_tvalid_nxt  = 1'b1;
          w_m_tdata_nxt   = c_s_axis_tdata[63:56];
          w_res_nxt       = {c_s_axis_tdata[55:0], 8'h00};
        end
      end
      S_TX_DATA: begin
        if (m_axis_tready) begin
          if (r_idx == 3'(BLK_BYTES - 1)) begin
            w_m_tvalid_nxt = 1'b0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_m_tdata_nxt = r_res[63:56];
            w_res_nxt     = {r_res[55:0], 8'h00};
            w_idx_nxt     = r_idx + 3'd1;
          end
        end
      end
      S_TX_STAT: begin
        if (m_axis_tready) begin
          w_m_tvalid_nxt = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_s_tready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_RX_KEY) ||
                     (w_state_nxt == S_RX_DATA);
    w_busy_nxt     = (w_state_nxt != S_IDLE);
  end

  assign s_axis_tready   = r_s_tready;
  assign m_axis_tdata    = r_m_tdata;
  assign m_axis_tvalid   = r_m_tvalid;
  assign c_m_axis_tdata  = r_blk;
  assign c_m_axis_tvalid = r_cm_tvalid;
  assign c_s_axis_tready = r_cs_tready;
  assign key             = r_key;
  assign busy            = r_busy;
  assign frame_err       = r_frame_err;

endmodule
